fifo_serial_tx: RTL



---
 rtl/fifo_serial_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fifo_serial_tx.sv
// Show-ahead FIFO consumer: pops one word at a time and sends it as an async
// serial frame (start, WIDTH data bits LSB first, optional even parity, stop bits).
module fifo_serial_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic [BW-1:0]    r_baud_cnt;
  logic             r_parity;
  logic             r_tx;
  logic             r_run;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_shift_next;
  logic [CW-1:0]    w_bit_next;
  logic [BW-1:0]    w_baud_next;
  logic             w_parity_next;
  logic             w_tx_next;
  logic             w_baud_last;
  logic             w_stop_last;
  logic             w_pop;

  assign w_baud_last = (r_baud_cnt == BAUD_LAST);
  assign w_stop_last = (r_state == STOP) && w_baud_last && (r_bit_cnt == STOP_LAST);
  // r_run keeps the pop strobe quiet until one full edge after reset release.
  assign w_pop = r_run && enable && !fifo_empty && ((r_state == IDLE) || w_stop_last);

  assign fifo_pop   = w_pop;
  assign tx         = r_tx;
  assign busy       = (r_state != IDLE);
  assign frame_done = w_stop_last;

  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_bit_next    = r_bit_cnt;
    w_baud_next   = r_baud_cnt;
    w_parity_next = r_parity;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_state_next  = START;
          w_shift_next  = fifo_data;
          w_parity_next = ^fifo_data;
          w_bit_next    = '0;
          w_baud_next   = '0;
        end
      end
      START: begin
        if (w_baud_last) begin
          w_state_next = DATA;
          w_baud_next  = '0;
          w_bit_next   = '0;
        end else begin
          w_baud_next = r_baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (r_bit_cnt == DATA_LAST) begin
            w_bit_next   = '0;
            w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            w_bit_next   = r_bit_cnt + CW'(1);
            w_shift_next = r_shift >> 1;
          end
        end else begin
          w_baud_next = r_baud_cnt + BW'(1);
        end
      end
      PARITY: begin
        if (w_baud_last) begin
          w_state_next = STOP;
          w_baud_next  = '0;
          w_bit_next   = '0;
        end else begin
          w_baud_next = r_baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (r_bit_cnt == STOP_LAST) begin
            w_bit_next = '0;
            // Back-to-back: the next word is popped in the last stop cycle.
            if (w_pop) begin
              w_state_next  = START;
              w_shift_next  = fifo_data;
              w_parity_next = ^fifo_data;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_bit_next = r_bit_cnt + CW'(1);
          end
        end else begin
          w_baud_next = r_baud_cnt + BW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // tx is registered from the next-state view so it lines up with r_state.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = w_parity_next;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_run      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_next;
      r_baud_cnt <= w_baud_next;
      r_parity   <= w_parity_next;
      r_tx       <= w_tx_next;
      r_run      <= 1'b1;
    end
  end

endmodule
